// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-serial program loader placed in front of the CPU.
// It receives a framed image over a valid/ready byte stream:
//   count N (16-bit LE), N little-endian 32-bit words, one XOR checksum byte.
// Each assembled word is written to instruction memory. A matching checksum
// releases the CPU. An oversize count or a bad checksum raises a sticky error.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   valid_i      stream byte valid
//   data_i       stream byte
//   ready_o      loader accepts a byte this cycle
//   imem_we_o    instruction-memory write strobe, one cycle per word
//   imem_addr_o  word address for the write
//   imem_data_o  word data for the write
//   cpu_rst_o    active-high CPU reset, dropped after a successful load
//   start_o      CPU start, high after a successful load
//   err_o        sticky frame error
//   words_o      number of words written so far
module imem_boot_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [7:0]        data_i,
    output logic              ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_o,
    output logic              start_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    localparam logic [2:0] StCntLo = 3'd0;
    localparam logic [2:0] StCntHi = 3'd1;
    localparam logic [2:0] StWord  = 3'd2;
    localparam logic [2:0] StCsum  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StErr   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [1:0]        byte_q, byte_d;
    logic [ADDR_W:0]   word_q, word_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              accept;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   word_inc;

    assign accept   = valid_i && ready_o;
    assign n_full   = {data_i, cnt_lo_q};
    assign word_inc = word_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        n_d      = n_q;
        byte_d   = byte_q;
        word_d   = word_q;
        asm_d    = asm_q;
        xor_d    = xor_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (accept) begin
            // The checksum byte itself is not folded into the running XOR.
            if (state_q != StCsum) begin
                xor_d = xor_q ^ data_i;
            end
            case (state_q)
                StCntLo: begin
                    cnt_lo_d = data_i;
                    state_d  = StCntHi;
                end
                StCntHi: begin
                    if (32'(n_full) > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        // N <= DEPTH <= 2^ADDR_W, so it fits in ADDR_W+1 bits.
                        n_d     = (ADDR_W + 1)'(n_full);
                        byte_d  = 2'd0;
                        word_d  = '0;
                        state_d = (n_full == 16'd0) ? StCsum : StWord;
                    end
                end
                StWord: begin
                    byte_d = byte_q + 2'd1;
                    case (byte_q)
                        2'd0: asm_d[7:0]   = data_i;
                        2'd1: asm_d[15:8]  = data_i;
                        2'd2: asm_d[23:16] = data_i;
                        default: begin
                            we_d   = 1'b1;
                            addr_d = word_q[ADDR_W-1:0];
                            data_d = {data_i, asm_q};
                            word_d = word_inc;
                            if (word_inc == n_q) begin
                                state_d = StCsum;
                            end
                        end
                    endcase
                end
                StCsum: begin
                    state_d = (data_i == xor_q) ? StDone : StErr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StCntLo;
            cnt_lo_q <= '0;
            n_q      <= '0;
            byte_q   <= '0;
            word_q   <= '0;
            asm_q    <= '0;
            xor_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            n_q      <= n_d;
            byte_q   <= byte_d;
            word_q   <= word_d;
            asm_q    <= asm_d;
            xor_q    <= xor_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Outputs decode from registered state only, so ready_o never looks at valid_i.
    always_comb begin
        ready_o = 1'b0;
        case (state_q)
            StCntLo, StCntHi, StWord, StCsum: ready_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    assign start_o     = (state_q == StDone);
    assign cpu_rst_o   = (state_q != StDone);
    assign err_o       = (state_q == StErr);
    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign words_o     = word_q;

endmodule
